// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register.
//
// Moves a data bundle and a control bundle from one CPU pipeline stage to the
// next using a valid/ready handshake. The hazard unit can freeze the stage
// (stall) or kill everything it holds (flush). When SKID = 1 a second entry
// absorbs one extra transfer, so in_ready comes from a register rather than
// from out_ready.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream holds a valid instruction
//   in_ready   - stage accepts an entry this cycle
//   in_data    - upstream data bundle (DATA_W bits)
//   in_ctrl    - upstream control bundle (CTRL_W bits)
//   stall      - freeze: no transfer on either side, state held
//   flush      - kill all held entries and insert a bubble
//   out_valid  - stage presents a valid head entry
//   out_ready  - downstream accepts the head entry
//   out_data   - head entry data
//   out_ctrl   - head entry control, zero whenever out_valid is low
//   occupancy  - number of held entries (0..2)
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam bit USE_SKID = (SKID != 32'sd0);

  // Goes high on the first clock edge after reset is released; keeps
  // in_ready low until then.
  logic rst_done_r;

  // Main (head) register M and skid register S.
  logic              m_valid_r;
  logic [DATA_W-1:0] m_data_r;
  logic [CTRL_W-1:0] m_ctrl_r;
  logic              s_valid_r;
  logic [DATA_W-1:0] s_data_r;
  logic [CTRL_W-1:0] s_ctrl_r;

  logic              m_valid_s;
  logic [DATA_W-1:0] m_data_s;
  logic [CTRL_W-1:0] m_ctrl_s;
  logic              s_valid_s;
  logic [DATA_W-1:0] s_data_s;
  logic [CTRL_W-1:0] s_ctrl_s;

  logic in_ready_s;
  logic out_valid_s;
  logic in_fire_s;
  logic out_fire_s;

  // Handshake: stall and flush hide the head entry and refuse new input.
  always_comb begin
    out_valid_s = m_valid_r & ~stall & ~flush;
    if (USE_SKID) begin
      // Depends only on registered state plus the hazard controls.
      in_ready_s = rst_done_r & ~s_valid_r & ~stall & ~flush;
    end else begin
      // Single entry: accept when empty or when the head leaves this edge.
      in_ready_s = rst_done_r & ~stall & ~flush & (~m_valid_r | out_ready);
    end
    in_fire_s  = in_valid & in_ready_s;
    out_fire_s = out_valid_s & out_ready;
  end

  // Next-state selection for the M/S entries (flush > stall > normal).
  always_comb begin
    m_valid_s = m_valid_r;
    m_data_s  = m_data_r;
    m_ctrl_s  = m_ctrl_r;
    s_valid_s = s_valid_r;
    s_data_s  = s_data_r;
    s_ctrl_s  = s_ctrl_r;
    if (flush) begin
      // Data is left in place; only valid bits and control are killed.
      m_valid_s = 1'b0;
      m_ctrl_s  = '0;
      s_valid_s = 1'b0;
      s_ctrl_s  = '0;
    end else if (USE_SKID) begin
      if (s_valid_r) begin
        // Skid full means in_ready is low; only a drain can happen.
        if (out_fire_s) begin
          m_valid_s = 1'b1;
          m_data_s  = s_data_r;
          m_ctrl_s  = s_ctrl_r;
          s_valid_s = 1'b0;
          s_ctrl_s  = '0;
        end else begin
          m_valid_s = m_valid_r;
        end
      end else if (in_fire_s) begin
        if (!m_valid_r || out_fire_s) begin
          m_valid_s = 1'b1;
          m_data_s  = in_data;
          m_ctrl_s  = in_ctrl;
        end else begin
          s_valid_s = 1'b1;
          s_data_s  = in_data;
          s_ctrl_s  = in_ctrl;
        end
      end else if (out_fire_s) begin
        m_valid_s = 1'b0;
      end else begin
        m_valid_s = m_valid_r;
      end
    end else begin
      if (in_fire_s) begin
        m_valid_s = 1'b1;
        m_data_s  = in_data;
        m_ctrl_s  = in_ctrl;
      end else if (out_fire_s) begin
        m_valid_s = 1'b0;
      end else begin
        m_valid_s = m_valid_r;
      end
    end
  end

  // Reset-release tracker for in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_ctrl_r  <= '0;
      s_valid_r <= 1'b0;
      s_data_r  <= '0;
      s_ctrl_r  <= '0;
    end else begin
      m_valid_r <= m_valid_s;
      m_data_r  <= m_data_s;
      m_ctrl_r  <= m_ctrl_s;
      s_valid_r <= s_valid_s;
      s_data_r  <= s_data_s;
      s_ctrl_r  <= s_ctrl_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = m_data_r;
  // A bubble must never carry write enables downstream.
  assign out_ctrl  = out_valid_s ? m_ctrl_r : {CTRL_W{1'b0}};
  assign occupancy = {1'b0, m_valid_r} + {1'b0, s_valid_r};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;

  // SKID = 1 instance signals
  logic        iv1, st1, fl1, ordy1;
  logic [63:0] d1;
  logic [7:0]  c1;
  logic        ir1, ov1;
  logic [63:0] od1;
  logic [7:0]  oc1;
  logic [1:0]  occ1;

  // SKID = 0 instance signals
  logic        iv0, st0, fl0, ordy0;
  logic [63:0] d0;
  logic [7:0]  c0;
  logic        ir0, ov0;
  logic [63:0] od0;
  logic [7:0]  oc0;
  logic [1:0]  occ0;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic [7:0]  c;
    logic        st;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_od;
    logic [7:0]  e_oc;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tab1[$];
  vec_t tab0[$];

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .in_data(d1), .in_ctrl(c1),
    .stall(st1), .flush(fl1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0), .in_ctrl(c0),
    .stall(st0), .flush(fl0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic [7:0] c,
                              input logic st, input logic fl, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [63:0] e_od,
                              input logic [7:0] e_oc, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.st = st; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_skid(input string tag);
    check({tag, " skid1 in_ready"},  {63'd0, ir1}, 64'd0);
    check({tag, " skid1 out_valid"}, {63'd0, ov1}, 64'd0);
    check({tag, " skid1 out_data"},  od1, 64'd0);
    check({tag, " skid1 out_ctrl"},  {56'd0, oc1}, 64'd0);
    check({tag, " skid1 occupancy"}, {62'd0, occ1}, 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    iv1 = 1'b1; d1 = 64'h99; c1 = 8'hFF; st1 = 1'b0; fl1 = 1'b0; ordy1 = 1'b1;
    iv0 = 1'b1; d0 = 64'h99; c0 = 8'hFF; st0 = 1'b0; fl0 = 1'b0; ordy0 = 1'b1;

    // SKID = 1 table:             iv  data    ctrl  st  fl  ordy | ir  ov  out_data ctrl occ
    tab1.push_back(mk(1'b1, 64'h1,  8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  8'h00, 2'd0));
    tab1.push_back(mk(1'b1, 64'h2,  8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1,  8'h81, 2'd1));
    tab1.push_back(mk(1'b1, 64'h3,  8'h83, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2,  8'h82, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h3,  8'h83, 2'd1));
    // backpressure: A, B accepted, C held upstream
    tab1.push_back(mk(1'b1, 64'hA,  8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h3,  8'h00, 2'd0));
    tab1.push_back(mk(1'b1, 64'hB,  8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA,  8'h0A, 2'd1));
    tab1.push_back(mk(1'b1, 64'hC,  8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA,  8'h0A, 2'd2));
    tab1.push_back(mk(1'b1, 64'hC,  8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA,  8'h0A, 2'd2));
    tab1.push_back(mk(1'b1, 64'hC,  8'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hA,  8'h0A, 2'd2));
    tab1.push_back(mk(1'b1, 64'hC,  8'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'hB,  8'h0B, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'hC,  8'h0C, 2'd1));
    // stall for 3 cycles with head 0x55 / ctrl 0x07
    tab1.push_back(mk(1'b1, 64'h55, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hC,  8'h00, 2'd0));
    tab1.push_back(mk(1'b1, 64'h66, 8'h06, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h55, 8'h00, 2'd1));
    tab1.push_back(mk(1'b1, 64'h66, 8'h06, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h55, 8'h00, 2'd1));
    tab1.push_back(mk(1'b1, 64'h66, 8'h06, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h55, 8'h00, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h55, 8'h07, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h55, 8'h07, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h55, 8'h00, 2'd0));
    // fill to occupancy 2, then flush with 0x77 offered
    tab1.push_back(mk(1'b1, 64'h21, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h55, 8'h00, 2'd0));
    tab1.push_back(mk(1'b1, 64'h22, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h21, 8'h31, 2'd1));
    tab1.push_back(mk(1'b1, 64'h77, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h21, 8'h00, 2'd2));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h21, 8'h00, 2'd0));
    // flush + stall together acts as flush
    tab1.push_back(mk(1'b1, 64'h40, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h21, 8'h00, 2'd0));
    tab1.push_back(mk(1'b1, 64'h78, 8'h78, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 8'h00, 2'd1));
    tab1.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h40, 8'h00, 2'd0));

    // SKID = 0 table (starts right after a reset, data regs zero)
    tab0.push_back(mk(1'b1, 64'h10, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  8'h00, 2'd0));
    tab0.push_back(mk(1'b1, 64'h11, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h10, 8'h11, 2'd1));
    tab0.push_back(mk(1'b1, 64'h11, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h10, 8'h11, 2'd1));
    tab0.push_back(mk(1'b1, 64'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h11, 8'h12, 2'd1));
    tab0.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h12, 8'h13, 2'd1));
    tab0.push_back(mk(1'b1, 64'h13, 8'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h12, 8'h00, 2'd0));
    tab0.push_back(mk(1'b1, 64'h14, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h12, 8'h00, 2'd0));
    tab0.push_back(mk(1'b1, 64'h77, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h14, 8'h00, 2'd1));
    tab0.push_back(mk(1'b0, 64'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h14, 8'h00, 2'd0));

    // Reset state while rst_n is low, with in_valid offered
    #2;
    check_skid("reset");
    check("reset skid0 in_ready",  {63'd0, ir0}, 64'd0);
    check("reset skid0 occupancy", {62'd0, occ0}, 64'd0);

    // Release between edges: in_ready stays low until the next rising edge
    #10;
    rst_n = 1'b1;
    #1;
    check("post-release skid1 in_ready", {63'd0, ir1}, 64'd0);
    iv1 = 1'b0; iv0 = 1'b0;

    for (int i = 0; i < tab1.size(); i++) begin
      @(negedge clk);
      iv1 = tab1[i].iv; d1 = tab1[i].d; c1 = tab1[i].c;
      st1 = tab1[i].st; fl1 = tab1[i].fl; ordy1 = tab1[i].ordy;
      #1;
      check($sformatf("skid1 row%0d in_ready", i),  {63'd0, ir1},  {63'd0, tab1[i].e_ir});
      check($sformatf("skid1 row%0d out_valid", i), {63'd0, ov1},  {63'd0, tab1[i].e_ov});
      check($sformatf("skid1 row%0d out_data", i),  od1,           tab1[i].e_od);
      check($sformatf("skid1 row%0d out_ctrl", i),  {56'd0, oc1},  {56'd0, tab1[i].e_oc});
      check($sformatf("skid1 row%0d occupancy", i), {62'd0, occ1}, {62'd0, tab1[i].e_occ});
    end

    // Asynchronous reset mid-operation at occupancy 2
    @(negedge clk);
    iv1 = 1'b1; d1 = 64'h91; c1 = 8'h01; st1 = 1'b0; fl1 = 1'b0; ordy1 = 1'b0;
    @(negedge clk);
    d1 = 64'h92; c1 = 8'h02;
    @(negedge clk);
    #1;
    check("pre-reset occupancy", {62'd0, occ1}, 64'd2);
    check("pre-reset out_data",  od1, 64'h91);
    check("pre-reset out_ctrl",  {56'd0, oc1}, 64'h01);
    #1;
    rst_n = 1'b0;
    #1;
    check_skid("async reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    iv1 = 1'b0;

    for (int i = 0; i < tab0.size(); i++) begin
      @(negedge clk);
      iv0 = tab0[i].iv; d0 = tab0[i].d; c0 = tab0[i].c;
      st0 = tab0[i].st; fl0 = tab0[i].fl; ordy0 = tab0[i].ordy;
      #1;
      check($sformatf("skid0 row%0d in_ready", i),  {63'd0, ir0},  {63'd0, tab0[i].e_ir});
      check($sformatf("skid0 row%0d out_valid", i), {63'd0, ov0},  {63'd0, tab0[i].e_ov});
      check($sformatf("skid0 row%0d out_data", i),  od0,           tab0[i].e_od);
      check($sformatf("skid0 row%0d out_ctrl", i),  {56'd0, oc0},  {56'd0, tab0[i].e_oc});
      check($sformatf("skid0 row%0d occupancy", i), {62'd0, occ0}, {62'd0, tab0[i].e_occ});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
